// File: rtl/sfr_multitimer.sv
// Per-core SFR block: ID/control registers, IRQ enables, software IRQs and TIMER_NUM prescaled timers.
// Optional watchdog (WDT_CTRL/WDT_PERIOD/WDT_KICK at F0..F8) is built when SFR_WDT_EN is defined.
module sfr_multitimer #(
  parameter logic [31:0] corenum          = 32'd0,
  parameter bit          SW_RESET_DEFAULT = 1'b0,
  parameter int          IRQ_NUM_POW      = 4,
  parameter int          TIMER_NUM        = 4,
  parameter int          PRESC_W          = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      host_req,
  output logic                      host_ack,
  input  logic                      host_we,
  input  logic [31:0]               host_addr,
  input  logic [3:0]                host_be,
  input  logic [31:0]               host_wdata,
  output logic                      host_resp,
  output logic [31:0]               host_rdata,
  output logic                      sw_reset_o,
  output logic [2**IRQ_NUM_POW-1:0] irq_en_bo,
  output logic                      irq_timer_o,
  output logic [TIMER_NUM-1:0]      tmr_pulse_bo,
  output logic                      sgi_req_o,
  output logic [IRQ_NUM_POW-1:0]    sgi_code_bo
);

  localparam int         IRQ_W = 2**IRQ_NUM_POW;
  localparam logic [3:0] TN4   = 4'(TIMER_NUM);

  logic                   sw_reset_r, autoclr_r, sw_reset_o_r;
  logic [IRQ_W-1:0]       irq_en_r;
  logic                   sgi_req_r;
  logic [IRQ_NUM_POW-1:0] sgi_code_r;
  logic                   host_resp_r;
  logic [31:0]            host_rdata_r;
  logic [TIMER_NUM-1:0]   status_r, pulse_r;
  logic                   irq_timer_r;

  logic [2:0]             tctrl_r   [TIMER_NUM];
  logic [31:0]            tperiod_r [TIMER_NUM];
  logic [31:0]            tvalue_r  [TIMER_NUM];
  logic [PRESC_W-1:0]     tpresc_r  [TIMER_NUM];
  logic [PRESC_W-1:0]     tpcnt_r   [TIMER_NUM];

  logic                   wr_s, rd_s, tmr_hit_s, wdt_fire_s;
  logic [7:0]             addr_s;
  logic [3:0]             tsel_s;
  logic [31:0]            rdata_s;
  logic [TIMER_NUM-1:0]   ctrl_wr_s, period_wr_s, presc_wr_s, tick_s, expire_s, tirq_en_s, w1c_s;
  logic                   unused_s;

  assign wr_s      = host_req & host_we;
  assign rd_s      = host_req & ~host_we;
  assign addr_s    = host_addr[7:0];
  // Timer windows start at 0x20; addresses below wrap to 14/15 and miss.
  assign tsel_s    = addr_s[7:4] - 4'd2;
  assign tmr_hit_s = (tsel_s < TN4);
  assign w1c_s     = (wr_s && addr_s == 8'h18) ? host_wdata[TIMER_NUM-1:0] : {TIMER_NUM{1'b0}};
  assign unused_s  = ^{host_addr[31:8], host_addr[1:0], host_be};

  assign host_ack     = host_req;
  assign host_resp    = host_resp_r;
  assign host_rdata   = host_rdata_r;
  assign sw_reset_o   = sw_reset_o_r;
  assign irq_en_bo    = irq_en_r;
  assign irq_timer_o  = irq_timer_r;
  assign tmr_pulse_bo = pulse_r;
  assign sgi_req_o    = sgi_req_r;
  assign sgi_code_bo  = sgi_code_r;

  // Per-timer write strobes, tick and expiry decode
  always_comb begin
    ctrl_wr_s   = {TIMER_NUM{1'b0}};
    period_wr_s = {TIMER_NUM{1'b0}};
    presc_wr_s  = {TIMER_NUM{1'b0}};
    tick_s      = {TIMER_NUM{1'b0}};
    expire_s    = {TIMER_NUM{1'b0}};
    tirq_en_s   = {TIMER_NUM{1'b0}};
    for (int i = 0; i < TIMER_NUM; i++) begin
      ctrl_wr_s[i]   = wr_s && tmr_hit_s && (tsel_s == 4'(i)) && (addr_s[3:2] == 2'd0);
      period_wr_s[i] = wr_s && tmr_hit_s && (tsel_s == 4'(i)) && (addr_s[3:2] == 2'd1);
      presc_wr_s[i]  = wr_s && tmr_hit_s && (tsel_s == 4'(i)) && (addr_s[3:2] == 2'd3);
      tick_s[i]      = tctrl_r[i][0] && (tpcnt_r[i] == tpresc_r[i]);
      expire_s[i]    = tick_s[i] && (tvalue_r[i] == tperiod_r[i]) && !ctrl_wr_s[i];
      tirq_en_s[i]   = tctrl_r[i][2];
    end
  end

`ifdef SFR_WDT_EN
  logic        wdt_en_r, wdt_fired_r;
  logic [31:0] wdt_period_r, wcnt_r;
  logic        wdt_ctrl_wr_s, wdt_kick_s;

  assign wdt_ctrl_wr_s = wr_s && (addr_s == 8'hF0);
  assign wdt_kick_s    = wr_s && (addr_s == 8'hF8);
  assign wdt_fire_s    = wdt_en_r && !wdt_kick_s && !wdt_ctrl_wr_s && (wcnt_r == wdt_period_r);

  // Watchdog counter; a kick always wins over a same-cycle expiry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_en_r     <= 1'b0;
      wdt_fired_r  <= 1'b0;
      wdt_period_r <= 32'd0;
      wcnt_r       <= 32'd0;
    end else begin
      if (wr_s && addr_s == 8'hF4) wdt_period_r <= host_wdata;
      if (wdt_ctrl_wr_s) begin
        wdt_en_r <= host_wdata[0];
        wcnt_r   <= 32'd0;
      end else if (wdt_kick_s) begin
        wcnt_r <= 32'd0;
      end else if (wdt_fire_s) begin
        wdt_en_r    <= 1'b0;
        wdt_fired_r <= 1'b1;
      end else if (wdt_en_r) begin
        wcnt_r <= wcnt_r + 32'd1;
      end
    end
  end
`else
  assign wdt_fire_s = 1'b0;
`endif

  // Register read mux
  always_comb begin
    rdata_s = 32'd0;
    case (addr_s)
      8'h00:   rdata_s = 32'hdeadbeef;
      8'h04:   rdata_s = {30'd0, autoclr_r, sw_reset_r};
      8'h08:   rdata_s = corenum;
      8'h0C:   rdata_s = {16'd0, 8'(TIMER_NUM), 8'(IRQ_NUM_POW)};
      8'h10:   rdata_s = 32'(irq_en_r);
      8'h14:   rdata_s = 32'(sgi_code_r);
      8'h18:   rdata_s = 32'(status_r);
`ifdef SFR_WDT_EN
      8'hF0:   rdata_s = {23'd0, wdt_fired_r, 7'd0, wdt_en_r};
      8'hF4:   rdata_s = wdt_period_r;
`endif
      default: rdata_s = 32'd0;
    endcase
    for (int i = 0; i < TIMER_NUM; i++) begin
      if (tmr_hit_s && tsel_s == 4'(i)) begin
        case (addr_s[3:2])
          2'd0:    rdata_s = {29'd0, tctrl_r[i]};
          2'd1:    rdata_s = tperiod_r[i];
          2'd2:    rdata_s = tvalue_r[i];
          2'd3:    rdata_s = 32'(tpresc_r[i]);
          default: rdata_s = 32'd0;
        endcase
      end else begin
        rdata_s = rdata_s;
      end
    end
  end

  // Control, IRQ enable, SGI and bus response registers (kept across soft reset)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_reset_r   <= SW_RESET_DEFAULT;
      autoclr_r    <= 1'b0;
      sw_reset_o_r <= 1'b1;
      irq_en_r     <= {IRQ_W{1'b0}};
      sgi_req_r    <= 1'b0;
      sgi_code_r   <= {IRQ_NUM_POW{1'b0}};
      host_resp_r  <= 1'b0;
      host_rdata_r <= 32'd0;
    end else begin
      sw_reset_o_r <= sw_reset_r;
      if (wdt_fire_s) begin
        sw_reset_r <= 1'b1;
        autoclr_r  <= 1'b1;
      end else if (wr_s && addr_s == 8'h04) begin
        sw_reset_r <= host_wdata[0];
        autoclr_r  <= host_wdata[1];
      end else if (sw_reset_r && autoclr_r) begin
        sw_reset_r <= 1'b0;
      end
      if (wr_s && addr_s == 8'h10) irq_en_r <= host_wdata[IRQ_W-1:0];
      sgi_req_r <= wr_s && (addr_s == 8'h14);
      if (wr_s && addr_s == 8'h14) sgi_code_r <= host_wdata[IRQ_NUM_POW-1:0];
      host_resp_r  <= rd_s;
      host_rdata_r <= rd_s ? rdata_s : 32'd0;
    end
  end

  // Timer prescalers, counters and config; a CTRL write overrides the timer's own update
  always_ff @(posedge clk_i) begin
    if (rst_i || sw_reset_o_r) begin
      for (int i = 0; i < TIMER_NUM; i++) begin
        tctrl_r[i]   <= 3'd0;
        tperiod_r[i] <= 32'd0;
        tvalue_r[i]  <= 32'd0;
        tpresc_r[i]  <= {PRESC_W{1'b0}};
        tpcnt_r[i]   <= {PRESC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < TIMER_NUM; i++) begin
        if (ctrl_wr_s[i]) begin
          tctrl_r[i]  <= host_wdata[2:0];
          tvalue_r[i] <= 32'd0;
          tpcnt_r[i]  <= {PRESC_W{1'b0}};
        end else if (tctrl_r[i][0]) begin
          if (tick_s[i]) begin
            tpcnt_r[i] <= {PRESC_W{1'b0}};
            if (expire_s[i]) begin
              tvalue_r[i]   <= 32'd0;
              tctrl_r[i][0] <= tctrl_r[i][1];
            end else begin
              tvalue_r[i] <= tvalue_r[i] + 32'd1;
            end
          end else begin
            tpcnt_r[i] <= tpcnt_r[i] + PRESC_W'(1'b1);
          end
        end
        if (period_wr_s[i]) tperiod_r[i] <= host_wdata;
        if (presc_wr_s[i])  tpresc_r[i]  <= host_wdata[PRESC_W-1:0];
      end
    end
  end

  // Sticky status (expiry beats W1C), expiry pulses and timer IRQ level
  always_ff @(posedge clk_i) begin
    if (rst_i || sw_reset_o_r) begin
      status_r    <= {TIMER_NUM{1'b0}};
      pulse_r     <= {TIMER_NUM{1'b0}};
      irq_timer_r <= 1'b0;
    end else begin
      status_r    <= (status_r & ~w1c_s) | expire_s;
      pulse_r     <= expire_s;
      irq_timer_r <= |(status_r & tirq_en_s);
    end
  end

endmodule

// File: tb/tb_sfr_multitimer.sv
// Directed self-checking bench for sfr_multitimer (TIMER_NUM=4, IRQ_NUM_POW=4, corenum=3).
// Watchdog checks follow SFR_WDT_EN the same way the design does.
module tb_sfr_multitimer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        host_ack, host_resp;
  logic [31:0] host_rdata;
  logic        sw_reset_o, irq_timer_o, sgi_req_o;
  logic [15:0] irq_en_bo;
  logic [3:0]  tmr_pulse_bo;
  logic [3:0]  sgi_code_bo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  sfr_multitimer #(
    .corenum(32'd3), .SW_RESET_DEFAULT(1'b0), .IRQ_NUM_POW(4), .TIMER_NUM(4), .PRESC_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req(host_req), .host_ack(host_ack), .host_we(host_we), .host_addr(host_addr),
    .host_be(host_be), .host_wdata(host_wdata), .host_resp(host_resp), .host_rdata(host_rdata),
    .sw_reset_o(sw_reset_o), .irq_en_bo(irq_en_bo), .irq_timer_o(irq_timer_o),
    .tmr_pulse_bo(tmr_pulse_bo), .sgi_req_o(sgi_req_o), .sgi_code_bo(sgi_code_bo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    host_req = 1'b1; host_we = 1'b1; host_addr = {24'd0, a}; host_wdata = d;
    @(negedge clk_i);
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_i);
    host_req = 1'b1; host_we = 1'b0; host_addr = {24'd0, a};
    check_eq("ack", 32'(host_ack), 32'd1);
    @(negedge clk_i);
    host_req = 1'b0;
    check_eq("resp", 32'(host_resp), 32'd1);
    d = host_rdata;
  endtask

  task automatic wait_pulse(input int b, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (!tmr_pulse_bo[b] && cycles < budget);
  endtask

  task automatic wait_swrst(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (!sw_reset_o && cycles < budget);
  endtask

  logic [31:0] rd;
  int          cyc;
  int          cnt;

  initial begin
    rst_i = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 32'd0;
    host_wdata = 32'd0; host_be = 4'hF;
    repeat (3) @(negedge clk_i);
    check_eq("rst_sw_reset", 32'(sw_reset_o), 32'd1);
    check_eq("rst_irq_en", 32'(irq_en_bo), 32'd0);
    check_eq("rst_pulse", 32'(tmr_pulse_bo), 32'd0);
    check_eq("rst_irq_timer", 32'(irq_timer_o), 32'd0);
    check_eq("rst_sgi", 32'(sgi_req_o), 32'd0);
    check_eq("rst_resp", 32'(host_resp), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_sw_reset", 32'(sw_reset_o), 32'd0);

    // identification registers
    bus_read(8'h00, rd); check_eq("idcode", rd, 32'hdeadbeef);
    @(negedge clk_i);
    check_eq("resp_one_cycle", 32'(host_resp), 32'd0);
    bus_read(8'h08, rd); check_eq("corenum", rd, 32'd3);
    bus_read(8'h0C, rd); check_eq("params", rd, 32'h0000_0404);
    bus_read(8'h1C, rd); check_eq("unmapped", rd, 32'd0);
    bus_write(8'h10, 32'h0000_00A5);
    check_eq("irq_en_out", 32'(irq_en_bo), 32'h0000_00A5);

    // T0 periodic: PRESC=0, PERIOD=9 -> every 10 clocks
    bus_write(8'h2C, 32'd0);
    bus_write(8'h24, 32'd9);
    bus_write(8'h20, 32'd7);
    wait_pulse(0, 40, cyc); check_eq("t0_first", 32'(cyc), 32'd10);
    wait_pulse(0, 40, cyc); check_eq("t0_period", 32'(cyc), 32'd10);
    @(negedge clk_i);
    check_eq("t0_pulse_width", 32'(tmr_pulse_bo[0]), 32'd0);
    check_eq("t0_irq_high", 32'(irq_timer_o), 32'd1);
    bus_write(8'h18, 32'd1);
    @(negedge clk_i);
    check_eq("t0_irq_cleared", 32'(irq_timer_o), 32'd0);
    bus_read(8'h18, rd); check_eq("t0_status_cleared", rd & 32'd1, 32'd0);

    // W1C in the same cycle as a T0 expiry: set wins
    wait_pulse(0, 40, cyc);
    repeat (8) @(negedge clk_i);
    bus_write(8'h18, 32'd1);
    check_eq("t0_collide_pulse", 32'(tmr_pulse_bo[0]), 32'd1);
    bus_read(8'h18, rd); check_eq("status_set_wins", rd & 32'd1, 32'd1);

    // T1 one-shot: PRESC=3, PERIOD=4 -> single pulse 20 clocks later
    bus_write(8'h3C, 32'd3);
    bus_write(8'h34, 32'd4);
    bus_write(8'h30, 32'd1);
    wait_pulse(1, 40, cyc); check_eq("t1_oneshot", 32'(cyc), 32'd20);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (tmr_pulse_bo[1]) cnt++;
    end
    check_eq("t1_no_repeat", 32'(cnt), 32'd0);
    bus_read(8'h30, rd); check_eq("t1_en_off", rd, 32'd0);
    bus_read(8'h18, rd); check_eq("t1_status", (rd >> 1) & 32'd1, 32'd1);

    // SGI strobe and code
    bus_write(8'h14, 32'h5);
    check_eq("sgi_req", 32'(sgi_req_o), 32'd1);
    check_eq("sgi_code", 32'(sgi_code_bo), 32'd5);
    @(negedge clk_i);
    check_eq("sgi_req_1cyc", 32'(sgi_req_o), 32'd0);

    // T2 PRESC=0, PERIOD=0 expires every cycle
    bus_write(8'h4C, 32'd0);
    bus_write(8'h44, 32'd0);
    bus_write(8'h40, 32'd3);
    check_eq("t2_not_yet", 32'(tmr_pulse_bo[2]), 32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (tmr_pulse_bo[2]) cnt++;
    end
    check_eq("t2_every_cycle", 32'(cnt), 32'd3);
    bus_write(8'h40, 32'd0);
    check_eq("t2_ctrl_write_wins", 32'(tmr_pulse_bo[2]), 32'd0);

    // soft reset with autoclear while T0 runs
    bus_write(8'h04, 32'd3);
    check_eq("swr_before", 32'(sw_reset_o), 32'd0);
    @(negedge clk_i);
    check_eq("swr_high", 32'(sw_reset_o), 32'd1);
    @(negedge clk_i);
    check_eq("swr_low", 32'(sw_reset_o), 32'd0);
    bus_read(8'h20, rd); check_eq("swr_t0_ctrl", rd, 32'd0);
    bus_read(8'h28, rd); check_eq("swr_t0_value", rd, 32'd0);
    bus_read(8'h18, rd); check_eq("swr_status", rd, 32'd0);
    bus_read(8'h10, rd); check_eq("swr_irq_en_kept", rd, 32'h0000_00A5);
    bus_read(8'h04, rd); check_eq("swr_ctrl", rd, 32'd2);
    check_eq("swr_irq_timer", 32'(irq_timer_o), 32'd0);

`ifdef SFR_WDT_EN
    bus_write(8'hF4, 32'd50);
    bus_write(8'hF0, 32'd1);
    cnt = 0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk_i);
      if (sw_reset_o) cnt++;
    end
    bus_write(8'hF8, 32'd0);
    wait_swrst(120, cyc);
    check_eq("wdt_no_early_reset", 32'(cnt), 32'd0);
    check_eq("wdt_fire_after_kick", 32'(cyc), 32'd52);
    bus_read(8'hF0, rd); check_eq("wdt_fired", rd, 32'h0000_0100);
`else
    bus_write(8'hF0, 32'd1);
    bus_read(8'hF0, rd); check_eq("wdt_absent", rd, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
